// File: rtl/fft_capture_pkg.sv
// Shared types and constants for the FFT result capture block.
//   state_t      : capture FSM states
//   ERR_*        : bit positions inside err_flags
//   DEF_*        : default widths for the capture datapath
package fft_capture_pkg;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_EXP_W  = 6;
  localparam int DEF_ADDR_W = 13;

  localparam int ERR_SHORT = 0;  // eop before the last bin
  localparam int ERR_LONG  = 1;  // last bin reached without eop
  localparam int ERR_SRC   = 2;  // FFT reported a nonzero error code
  localparam int ERR_SOP   = 3;  // sop seen while already capturing

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage magnitude-squared pipeline.
//   stage 1 : re*re and im*im registered (signed square, non-negative result)
//   stage 2 : sum registered, no saturation
// Ports:
//   clk, reset_n          clock, async active-low reset (clears valids only)
//   valid, addr, re, im   input beat and its bin address
//   stage1_valid          a beat is in flight in stage 1
//   mag_valid, mag_addr, mag   stage-2 result with its bin address
module mag_sq_pipe #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 13,
  parameter int MAG_W  = 2*DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  output logic                     stage1_valid,
  output logic                     mag_valid,
  output logic [ADDR_W-1:0]        mag_addr,
  output logic [MAG_W-1:0]         mag
);

  localparam int STAGES = 2;
  localparam int SQ_W   = 2*DATA_W-1;

  logic [STAGES:1]         vld_pipe;
  logic [ADDR_W-1:0]       addr_s1;
  logic [SQ_W-1:0]         re_sq, im_sq;
  logic signed [MAG_W-1:0] re_x, im_x;

  // Widen before multiplying so the product is computed at full width.
  assign re_x = MAG_W'(re);
  assign im_x = MAG_W'(im);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_pipe <= '0;
    else          vld_pipe <= {vld_pipe[STAGES-1:1], valid};
  end

  always_ff @(posedge clk) begin
    re_sq    <= SQ_W'(re_x * re_x);
    im_sq    <= SQ_W'(im_x * im_x);
    addr_s1  <= addr;
    mag      <= MAG_W'(re_sq) + MAG_W'(im_sq);
    mag_addr <= addr_s1;
  end

  assign stage1_valid = vld_pipe[1];
  assign mag_valid    = vld_pipe[STAGES];

endmodule

// File: rtl/fft_result_capture.sv
// Avalon-ST consumer for the FFT source port. Captures one frame of complex
// bins, stores |X|^2 per bin in an on-chip buffer, and tracks exponent, peak
// bin and framing errors.
// Ports:
//   clk, reset_n                 capture clock, async active-low reset
//   arm                          pulse: wait for the next frame (IDLE/DONE only)
//   source_*                     FFT source stream; source_ready is backpressure
//   rd_addr / rd_data            buffer read port, 1-cycle latency
//   busy, frame_done             status (WAIT_SOP/CAPTURE/DRAIN, DONE)
//   exp_out                      block exponent from the SOP beat
//   peak_bin, peak_mag           largest magnitude (lowest bin on ties)
//   err_flags                    sticky: short, long, source error, nested sop
module fft_result_capture
  import fft_capture_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int EXP_W     = DEF_EXP_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_LEN = 2**ADDR_W,
  parameter int MAG_W     = 2*DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     source_valid,
  input  logic                     source_sop,
  input  logic                     source_eop,
  input  logic [1:0]               source_error,
  input  logic [EXP_W-1:0]         source_exp,
  input  logic signed [DATA_W-1:0] source_real,
  input  logic signed [DATA_W-1:0] source_imag,
  output logic                     source_ready,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [MAG_W-1:0]         rd_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic [EXP_W-1:0]         exp_out,
  output logic [ADDR_W-1:0]        peak_bin,
  output logic [MAG_W-1:0]         peak_mag,
  output logic [3:0]               err_flags
);

  state_t            state, state_nxt;
  logic              accept, frame_beat, sop_beat, last_bin, term;
  logic [ADDR_W-1:0] cnt, beat_addr;
  logic [3:0]        err_nxt;
  logic              stage1_valid, mag_valid;
  logic [ADDR_W-1:0] mag_addr;
  logic [MAG_W-1:0]  mag;
  logic [MAG_W-1:0]  mem [FRAME_LEN];

  assign source_ready = (state == WAIT_SOP) || (state == CAPTURE);
  assign busy         = source_ready || (state == DRAIN);
  assign frame_done   = (state == DONE);

  // Non-sop beats in WAIT_SOP are accepted but never enter the frame.
  assign accept     = source_valid & source_ready;
  assign frame_beat = accept & ((state == CAPTURE) | source_sop);
  assign sop_beat   = frame_beat & source_sop;
  assign beat_addr  = source_sop ? '0 : cnt + 1'b1;
  assign last_bin   = (beat_addr == ADDR_W'(FRAME_LEN-1));
  assign term       = frame_beat & (source_eop | last_bin);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (arm) state_nxt = WAIT_SOP;
      WAIT_SOP: if (sop_beat) state_nxt = term ? DRAIN : CAPTURE;
      CAPTURE:  if (term) state_nxt = DRAIN;
      // The stage-2 beat (if any) is written on the same edge we leave.
      DRAIN:    if (!stage1_valid) state_nxt = DONE;
      DONE:     if (arm) state_nxt = WAIT_SOP;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    err_nxt = err_flags;
    if (frame_beat) begin
      if (source_sop && state == WAIT_SOP) err_nxt = '0;
      if (source_sop && state == CAPTURE)  err_nxt[ERR_SOP] = 1'b1;
      if (source_error != '0)              err_nxt[ERR_SRC] = 1'b1;
      if (source_eop && !last_bin)         err_nxt[ERR_SHORT] = 1'b1;
      if (!source_eop && last_bin)         err_nxt[ERR_LONG] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      exp_out   <= '0;
      peak_bin  <= '0;
      peak_mag  <= '0;
      err_flags <= '0;
    end else begin
      err_flags <= err_nxt;
      if (frame_beat) cnt <= beat_addr;
      if (sop_beat) exp_out <= source_exp;
      // Stale beats of an aborted frame may still land after the clear;
      // the new bin 0 loads unconditionally and overrides them.
      if (sop_beat) begin
        peak_bin <= '0;
        peak_mag <= '0;
      end else if (mag_valid && (mag_addr == '0 || mag > peak_mag)) begin
        peak_bin <= mag_addr;
        peak_mag <= mag;
      end
    end
  end

  mag_sq_pipe #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MAG_W  (MAG_W)
  ) u_mag (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid        (frame_beat),
    .addr         (beat_addr),
    .re           (source_real),
    .im           (source_imag),
    .stage1_valid (stage1_valid),
    .mag_valid    (mag_valid),
    .mag_addr     (mag_addr),
    .mag          (mag)
  );

  // Simple dual-port buffer; read-before-write on address collision.
  always_ff @(posedge clk) begin
    if (mag_valid) mem[mag_addr] <= mag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_fft_result_capture.sv
// Scoreboard bench for fft_result_capture: expected bin magnitudes are queued
// as beats are driven and checked through the read port once the frame ends.
module tb_fft_result_capture;

  localparam int DATA_W = 14, EXP_W = 6, ADDR_W = 13, FRAME_LEN = 8192, MAG_W = 28;

  logic                     clk = 1'b0, reset_n = 1'b0, arm = 1'b0;
  logic                     source_valid = 1'b0, source_sop = 1'b0, source_eop = 1'b0;
  logic [1:0]               source_error = '0;
  logic [EXP_W-1:0]         source_exp = '0;
  logic signed [DATA_W-1:0] source_real = '0, source_imag = '0;
  logic                     source_ready;
  logic [ADDR_W-1:0]        rd_addr = '0;
  logic [MAG_W-1:0]         rd_data;
  logic                     busy, frame_done;
  logic [EXP_W-1:0]         exp_out;
  logic [ADDR_W-1:0]        peak_bin;
  logic [MAG_W-1:0]         peak_mag;
  logic [3:0]               err_flags;

  typedef struct { int addr; int mag; } sb_t;
  sb_t sb[$];
  int  vecs = 0, miscompares = 0;
  int  pk_bin = 0, pk_mag = 0;

  fft_result_capture dut (
    .clk(clk), .reset_n(reset_n), .arm(arm),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error), .source_exp(source_exp),
    .source_real(source_real), .source_imag(source_imag), .source_ready(source_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
    .exp_out(exp_out), .peak_bin(peak_bin), .peak_mag(peak_mag), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  // Drive one beat and hold it until accepted (bounded).
  task automatic beat(input bit sop, input bit eop, input logic [1:0] er,
                      input logic [EXP_W-1:0] ex, input int re, input int im);
    bit rdy;
    int n = 0;
    source_valid = 1'b1; source_sop = sop; source_eop = eop; source_error = er;
    source_exp = ex; source_real = DATA_W'(re); source_imag = DATA_W'(im);
    forever begin
      @(negedge clk); rdy = source_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 50) begin
        vecs++; miscompares++;
        $display("FAIL beat_accept: source_ready stayed 0, required 1");
        break;
      end
    end
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = '0;
  endtask

  // Frame beat: drive it, update the reference peak, optionally queue a check.
  task automatic send(input int addr, input bit sop, input bit eop, input logic [1:0] er,
                      input logic [EXP_W-1:0] ex, input int re, input int im, input bit keep);
    int m;
    sb_t e;
    m = re*re + im*im;
    beat(sop, eop, er, ex, re, im);
    if (addr == 0 || m > pk_mag) begin pk_bin = addr; pk_mag = m; end
    if (keep) begin e.addr = addr; e.mag = m; sb.push_back(e); end
  endtask

  task automatic read_bin(input int a, output logic [MAG_W-1:0] d);
    rd_addr = ADDR_W'(a); tick(); d = rd_data;
  endtask

  // Edges counted from the accepting edge (inclusive) until frame_done.
  task automatic wait_done(output int n);
    n = 1;
    while (frame_done !== 1'b1 && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vecs++; if ({source_ready, busy, frame_done} !== 3'b000) begin miscompares++;
      $display("FAIL reset_status got %b want 000", {source_ready, busy, frame_done}); end
    vecs++; if (exp_out !== '0 || err_flags !== '0) begin miscompares++;
      $display("FAIL reset_exp_err got exp=%0h err=%b want 0", exp_out, err_flags); end
    vecs++; if (peak_bin !== '0 || peak_mag !== '0) begin miscompares++;
      $display("FAIL reset_peak got %0d/%0d want 0/0", peak_bin, peak_mag); end
    vecs++; if (rd_data !== '0) begin miscompares++;
      $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    reset_n = 1'b1; tick();
  endtask

  task automatic test_full_frame();
    int n; sb_t e; logic [MAG_W-1:0] d;
    do_arm();
    vecs++; if ({busy, source_ready, frame_done} !== 3'b110) begin miscompares++;
      $display("FAIL arm_wait_sop got %b want 110", {busy, source_ready, frame_done}); end
    for (int b = 0; b < FRAME_LEN; b++)
      send(b, b == 0, b == FRAME_LEN-1, 2'b00, 6'h11, b, 0,
           (b % 1024 == 0) || b == 100 || b == 150 || b == FRAME_LEN-1);
    vecs++; if (source_ready !== 1'b0) begin miscompares++;
      $display("FAIL full_ready_drop got %b want 0", source_ready); end
    wait_done(n);
    vecs++; if (n !== 3) begin miscompares++;
      $display("FAIL full_done_latency got %0d want 3", n); end
    vecs++; if (err_flags !== 4'b0000) begin miscompares++;
      $display("FAIL full_err got %b want 0000", err_flags); end
    vecs++; if (peak_bin !== 13'd8191 || peak_mag !== 28'd67092481) begin miscompares++;
      $display("FAIL full_peak got %0d/%0d want 8191/67092481", peak_bin, peak_mag); end
    vecs++; if (exp_out !== 6'h11) begin miscompares++;
      $display("FAIL full_exp got %0h want 11", exp_out); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); read_bin(e.addr, d);
      vecs++; if (d !== MAG_W'(e.mag)) begin miscompares++;
        $display("FAIL full_rd[%0d] got %0d want %0d", e.addr, d, e.mag); end
    end
  endtask

  task automatic test_short_frame();
    int n; sb_t e; logic [MAG_W-1:0] d;
    do_arm();
    for (int b = 0; b < 100; b++)
      send(b, b == 0, b == 99, 2'b00, (b == 0) ? 6'h2A : 6'h05, b, -b, b == 50 || b == 99);
    e.addr = 150; e.mag = 22500; sb.push_back(e);   // left over from the full frame
    wait_done(n);
    vecs++; if (n !== 3 || frame_done !== 1'b1) begin miscompares++;
      $display("FAIL short_done got lat=%0d done=%b want 3/1", n, frame_done); end
    vecs++; if (err_flags !== 4'b0001) begin miscompares++;
      $display("FAIL short_err got %b want 0001", err_flags); end
    vecs++; if (exp_out !== 6'h2A) begin miscompares++;
      $display("FAIL short_exp got %0h want 2a", exp_out); end
    vecs++; if (peak_bin !== ADDR_W'(pk_bin) || peak_mag !== 28'd19602) begin miscompares++;
      $display("FAIL short_peak got %0d/%0d want %0d/19602", peak_bin, peak_mag, pk_bin); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); read_bin(e.addr, d);
      vecs++; if (d !== MAG_W'(e.mag)) begin miscompares++;
        $display("FAIL short_rd[%0d] got %0d want %0d", e.addr, d, e.mag); end
    end
  endtask

  task automatic test_extremes();
    int n, v; sb_t e; logic [MAG_W-1:0] d;
    do_arm();
    for (int b = 0; b < FRAME_LEN; b++) begin
      v = (b == 5 || b == 9) ? -8192 : 0;
      send(b, b == 0, b == FRAME_LEN-1, 2'b00, 6'h01, v, v, b == 5 || b == 9 || b == 4000);
    end
    wait_done(n);
    vecs++; if (peak_bin !== 13'd5 || peak_mag !== 28'd134217728) begin miscompares++;
      $display("FAIL ext_peak got %0d/%0d want 5/134217728", peak_bin, peak_mag); end
    vecs++; if (err_flags !== 4'b0000) begin miscompares++;
      $display("FAIL ext_err got %b want 0000", err_flags); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); read_bin(e.addr, d);
      vecs++; if (d !== MAG_W'(e.mag)) begin miscompares++;
        $display("FAIL ext_rd[%0d] got %0d want %0d", e.addr, d, e.mag); end
    end
  endtask

  task automatic test_long_gaps();
    int n, seen; sb_t e; logic [MAG_W-1:0] d;
    do_arm();
    repeat (3) beat(1'b0, 1'b0, 2'b00, 6'h3F, 8000, 0);   // discarded before sop
    for (int b = 0; b < FRAME_LEN; b++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      send(b, b == 0, 1'b0, 2'b00, 6'h07, b % 100, (b % 37) - 18,
           (b % 1000 == 0) || b == FRAME_LEN-1);
    end
    vecs++; if (source_ready !== 1'b0) begin miscompares++;
      $display("FAIL long_ready_drop got %b want 0", source_ready); end
    source_valid = 1'b1; source_real = 14'sd5000; seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (source_ready) seen++; end
    source_valid = 1'b0; tick();
    vecs++; if (seen !== 0 || frame_done !== 1'b1) begin miscompares++;
      $display("FAIL long_hold got ready_cycles=%0d done=%b want 0/1", seen, frame_done); end
    vecs++; if (err_flags !== 4'b0010) begin miscompares++;
      $display("FAIL long_err got %b want 0010", err_flags); end
    vecs++; if (peak_bin !== ADDR_W'(pk_bin) || peak_mag !== MAG_W'(pk_mag)) begin miscompares++;
      $display("FAIL long_peak got %0d/%0d want %0d/%0d", peak_bin, peak_mag, pk_bin, pk_mag); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); read_bin(e.addr, d);
      vecs++; if (d !== MAG_W'(e.mag)) begin miscompares++;
        $display("FAIL long_rd[%0d] got %0d want %0d", e.addr, d, e.mag); end
    end
  endtask

  task automatic test_framing();
    int n; sb_t e; logic [MAG_W-1:0] d;
    do_arm();
    for (int b = 0; b < 50; b++) send(b, b == 0, 1'b0, 2'b00, 6'h05, 7, 0, 1'b0);
    send(0, 1'b1, 1'b0, 2'b00, 6'h09, 3, 4, 1'b1);
    for (int b = 1; b < 200; b++)
      send(b, 1'b0, b == 199, (b == 10) ? 2'b01 : 2'b00, 6'h05, 1, 1,
           b == 10 || b == 49 || b == 150);
    wait_done(n);
    vecs++; if (err_flags !== 4'b1101) begin miscompares++;
      $display("FAIL frm_err got %b want 1101", err_flags); end
    vecs++; if (exp_out !== 6'h09) begin miscompares++;
      $display("FAIL frm_exp got %0h want 09", exp_out); end
    vecs++; if (peak_bin !== 13'd0 || peak_mag !== 28'd25) begin miscompares++;
      $display("FAIL frm_peak got %0d/%0d want 0/25", peak_bin, peak_mag); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); read_bin(e.addr, d);
      vecs++; if (d !== MAG_W'(e.mag)) begin miscompares++;
        $display("FAIL frm_rd[%0d] got %0d want %0d", e.addr, d, e.mag); end
    end
  endtask

  task automatic test_reset_mid();
    int n; sb_t e; logic [MAG_W-1:0] d;
    do_arm();
    for (int b = 0; b < 4000; b++) send(b, b == 0, 1'b0, 2'b00, 6'h3F, b % 50, 3, 1'b0);
    reset_n = 1'b0; #2;
    vecs++; if ({source_ready, busy, frame_done} !== 3'b000) begin miscompares++;
      $display("FAIL rst_mid_status got %b want 000", {source_ready, busy, frame_done}); end
    vecs++; if (exp_out !== '0 || err_flags !== '0 || rd_data !== '0) begin miscompares++;
      $display("FAIL rst_mid_regs got exp=%0h err=%b rd=%0d want 0", exp_out, err_flags, rd_data); end
    vecs++; if (peak_bin !== '0 || peak_mag !== '0) begin miscompares++;
      $display("FAIL rst_mid_peak got %0d/%0d want 0/0", peak_bin, peak_mag); end
    tick(); tick(); reset_n = 1'b1; tick();
    do_arm();
    for (int b = 0; b < 16; b++) send(b, b == 0, b == 15, 2'b00, 6'h12, b + 1, 2, b == 0 || b == 3);
    wait_done(n);
    vecs++; if (n !== 3 || err_flags !== 4'b0001 || exp_out !== 6'h12) begin miscompares++;
      $display("FAIL rearm got lat=%0d err=%b exp=%0h want 3/0001/12", n, err_flags, exp_out); end
    vecs++; if (peak_bin !== 13'd15 || peak_mag !== 28'd260) begin miscompares++;
      $display("FAIL rearm_peak got %0d/%0d want 15/260", peak_bin, peak_mag); end
    while (sb.size() > 0) begin
      e = sb.pop_front(); read_bin(e.addr, d);
      vecs++; if (d !== MAG_W'(e.mag)) begin miscompares++;
        $display("FAIL rearm_rd[%0d] got %0d want %0d", e.addr, d, e.mag); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_extremes();
    test_long_gaps();
    test_framing();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
